// File: rtl/bt656_gen_pkg.sv
// Shared constants, types and the XY-word helper for the BT.656 test-pattern source.
// BAR_TABLE holds the 75% colour-bar YCbCr values, ordered left to right.
package bt656_gen_pkg;

    localparam logic [7:0] PREAMBLE_FF  = 8'hFF;
    localparam logic [7:0] PREAMBLE_00  = 8'h00;
    localparam logic [7:0] BLANK_CHROMA = 8'h80;
    localparam logic [7:0] BLANK_LUMA   = 8'h10;

    typedef enum logic {
        PAT_BARS = 1'b0,
        PAT_RAMP = 1'b1
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycbcr_t;

    localparam ycbcr_t BAR_TABLE [8] = '{
        '{8'd180, 8'd128, 8'd128},
        '{8'd162, 8'd44,  8'd142},
        '{8'd131, 8'd156, 8'd44 },
        '{8'd112, 8'd72,  8'd58 },
        '{8'd84,  8'd184, 8'd198},
        '{8'd65,  8'd100, 8'd212},
        '{8'd35,  8'd212, 8'd114},
        '{8'd16,  8'd128, 8'd128}
    };

    // Fourth preamble word: flag bits plus their protection bits.
    function automatic logic [7:0] xy_word(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_pattern_gen_if.sv
// BT.656 word stream with its framing strobes, driven by the pattern source.
interface bt656_pattern_gen_if;
    logic [7:0] bt656_data;
    logic       data_valid;
    logic       frame_start;
    logic       line_start;

    modport master (output bt656_data, data_valid, frame_start, line_start);
    modport slave  (input  bt656_data, data_valid, frame_start, line_start);
endinterface

// File: rtl/bt656_timing_counter.sv
// Word/line counters with idle/run control, plus F/V flags and line-region decode.
// word_off is the word offset inside whichever region h currently falls in.
module bt656_timing_counter
    import bt656_gen_pkg::*;
#(
    parameter int ACTIVE_WORDS = 1440,
    parameter int HBLANK_WORDS = 268,
    parameter int LINES        = 525,
    parameter int FIELD2_LINE  = 263,
    parameter int VB1_LEN      = 19,
    parameter int VB2_LEN      = 19,
    localparam int LINE_W      = ACTIVE_WORDS + HBLANK_WORDS + 8,
    localparam int H_W         = $clog2(LINE_W),
    localparam int L_W         = $clog2(LINES)
) (
    input  logic           ref_clock,
    input  logic           reset,
    input  logic           enable,
    output logic           running,
    output logic           frame_entry,
    output logic [L_W-1:0] line_count,
    output logic [H_W-1:0] word_off,
    output logic           f_bit,
    output logic           v_bit,
    output logic           in_eav,
    output logic           in_sav,
    output logic           in_hblank,
    output logic           in_active
);

    localparam int SAV_START = 4 + HBLANK_WORDS;
    localparam int ACT_START = 8 + HBLANK_WORDS;

    run_state_t     state_reg;
    logic [H_W-1:0] h_reg;
    logic [L_W-1:0] line_reg;
    logic           h_last;
    logic           line_last;

    assign h_last    = (h_reg == H_W'(LINE_W - 1));
    assign line_last = (line_reg == L_W'(LINES - 1));

    // High on the edge that puts the counters at (line 0, word 0) of a fresh frame.
    assign frame_entry = reset && enable && ((state_reg == ST_IDLE) || (h_last && line_last));

    always_ff @(posedge ref_clock) begin
        if (!reset || !enable) begin
            state_reg <= ST_IDLE;
            h_reg     <= '0;
            line_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_RUN;
                ST_RUN: begin
                    if (h_last) begin
                        h_reg    <= '0;
                        line_reg <= line_last ? '0 : line_reg + 1'b1;
                    end else begin
                        h_reg <= h_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign running    = (state_reg == ST_RUN);
    assign line_count = line_reg;

    assign f_bit = (line_reg >= L_W'(FIELD2_LINE));
    assign v_bit = (line_reg < L_W'(VB1_LEN)) ||
                   ((line_reg >= L_W'(FIELD2_LINE)) && (line_reg < L_W'(FIELD2_LINE + VB2_LEN)));

    assign in_eav    = (h_reg < H_W'(4));
    assign in_hblank = !in_eav && (h_reg < H_W'(SAV_START));
    assign in_sav    = (h_reg >= H_W'(SAV_START)) && (h_reg < H_W'(ACT_START));
    assign in_active = (h_reg >= H_W'(ACT_START));

    assign word_off = in_active ? h_reg - H_W'(ACT_START) :
                      in_sav    ? h_reg - H_W'(SAV_START) :
                      in_hblank ? h_reg - H_W'(4)         : h_reg;

endmodule

// File: rtl/bt656_pattern_gen.sv
// BT.656 525-line test-stream source: timing counter plus word mux and output registers.
// Active video is 75% colour bars or a luma ramp, chosen once per frame.
module bt656_pattern_gen
    import bt656_gen_pkg::*;
#(
    parameter int ACTIVE_WORDS = 1440,
    parameter int HBLANK_WORDS = 268,
    parameter int LINES        = 525,
    parameter int FIELD2_LINE  = 263,
    parameter int VB1_LEN      = 19,
    parameter int VB2_LEN      = 19
) (
    input  logic                       ref_clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       pattern_sel,
    bt656_pattern_gen_if.master        video
);

    localparam int LINE_W    = ACTIVE_WORDS + HBLANK_WORDS + 8;
    localparam int H_W       = $clog2(LINE_W);
    localparam int L_W       = $clog2(LINES);
    localparam int BAR_WORDS = ACTIVE_WORDS / 8;

    logic           running;
    logic           frame_entry;
    logic [L_W-1:0] line_count;
    logic [H_W-1:0] word_off;
    logic           f_bit;
    logic           v_bit;
    logic           in_eav;
    logic           in_sav;
    logic           in_hblank;
    logic           in_active;

    bt656_timing_counter #(
        .ACTIVE_WORDS (ACTIVE_WORDS),
        .HBLANK_WORDS (HBLANK_WORDS),
        .LINES        (LINES),
        .FIELD2_LINE  (FIELD2_LINE),
        .VB1_LEN      (VB1_LEN),
        .VB2_LEN      (VB2_LEN)
    ) timing (
        .ref_clock   (ref_clock),
        .reset       (reset),
        .enable      (enable),
        .running     (running),
        .frame_entry (frame_entry),
        .line_count  (line_count),
        .word_off    (word_off),
        .f_bit       (f_bit),
        .v_bit       (v_bit),
        .in_eav      (in_eav),
        .in_sav      (in_sav),
        .in_hblank   (in_hblank),
        .in_active   (in_active)
    );

    pattern_t   pattern_reg;
    logic [7:1] past_bar;
    logic [2:0] bar_idx;
    ycbcr_t     bar_colour;
    logic [7:0] ramp_y;
    logic [7:0] data_next;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       frame_start_reg;
    logic       line_start_reg;

    // Bar index = number of bar boundaries already passed in the active region.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
            assign past_bar[gi] = (word_off >= H_W'(gi * BAR_WORDS));
        end
    endgenerate

    assign bar_idx    = 3'($countones(past_bar));
    assign bar_colour = BAR_TABLE[bar_idx];
    // Active word offset / 2 is the pixel; luma steps once every 4 pixels.
    assign ramp_y     = 8'd16 + 8'(word_off >> 3);

    always_comb begin
        data_next = BLANK_LUMA;
        if (in_eav || in_sav) begin
            case (word_off[1:0])
                2'd0:    data_next = PREAMBLE_FF;
                2'd3:    data_next = xy_word(f_bit, v_bit, in_eav);
                default: data_next = PREAMBLE_00;
            endcase
        end else if (in_hblank || v_bit) begin
            data_next = word_off[0] ? BLANK_LUMA : BLANK_CHROMA;
        end else if (in_active && (pattern_reg == PAT_BARS)) begin
            case (word_off[1:0])
                2'd0:    data_next = bar_colour.cb;
                2'd2:    data_next = bar_colour.cr;
                default: data_next = bar_colour.y;
            endcase
        end else if (in_active) begin
            data_next = word_off[0] ? ramp_y : BLANK_CHROMA;
        end
    end

    always_ff @(posedge ref_clock) begin
        if (!reset) begin
            pattern_reg <= PAT_BARS;
        end else if (frame_entry) begin
            pattern_reg <= pattern_t'(pattern_sel);
        end

        if (!reset || !enable || !running) begin
            data_reg        <= BLANK_LUMA;
            valid_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end else begin
            data_reg        <= data_next;
            valid_reg       <= 1'b1;
            line_start_reg  <= in_eav && (word_off == '0);
            frame_start_reg <= in_eav && (word_off == '0) && (line_count == '0);
        end
    end

    assign video.bt656_data  = data_reg;
    assign video.data_valid  = valid_reg;
    assign video.frame_start = frame_start_reg;
    assign video.line_start  = line_start_reg;

endmodule

// File: tb/tb_bt656_pattern_gen.sv
// Scoreboard bench for the BT.656 pattern source on a shrunken raster; a line-level
// reference model queues expected words and a negedge monitor compares them.
module tb_bt656_pattern_gen;

    localparam int AW    = 64;
    localparam int HB    = 12;
    localparam int NL    = 30;
    localparam int F2    = 15;
    localparam int VB1   = 3;
    localparam int VB2   = 3;
    localparam int LW    = AW + HB + 8;
    localparam int ACT   = 8 + HB;
    localparam int FRAME = LW * NL;

    logic ref_clock = 1'b0;
    logic reset;
    logic enable;
    logic pattern_sel;

    always #5 ref_clock = ~ref_clock;

    bt656_pattern_gen_if video_if();

    bt656_pattern_gen #(
        .ACTIVE_WORDS (AW),
        .HBLANK_WORDS (HB),
        .LINES        (NL),
        .FIELD2_LINE  (F2),
        .VB1_LEN      (VB1),
        .VB2_LEN      (VB2)
    ) dut (
        .ref_clock   (ref_clock),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .video       (video_if)
    );

    typedef struct {
        logic [7:0] data;
        logic       fs;
        logic       ls;
        int         line;
        int         h;
        bit         ramp;
    } exp_t;

    exp_t q[$];
    logic exp_valid = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;

    int bar_y  [8] = '{180, 162, 131, 112, 84, 65, 35, 16};
    int bar_cb [8] = '{128, 44, 156, 72, 184, 100, 212, 128};
    int bar_cr [8] = '{128, 142, 44, 58, 198, 212, 114, 128};

    always @(posedge ref_clock) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want,
                          input int l, input int h);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %02h want %02h (line %0d word %0d)", name, got, want, l, h);
        end
    endtask

    function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] preamble(input int i, input logic [7:0] xyw);
        if (i == 0) return 8'hFF;
        if (i == 3) return xyw;
        return 8'h00;
    endfunction

    // Expected word at (line, h) straight from the line-layout rules.
    function automatic logic [7:0] ref_word(input int line, input int h, input bit ramp);
        bit f, v;
        int a, bar;
        f = (line >= F2);
        v = (line < VB1) || (line >= F2 && line < F2 + VB2);
        if (h < 4) return preamble(h, xy(f, v, 1'b1));
        if (h < 4 + HB) return ((h - 4) % 2 == 0) ? 8'h80 : 8'h10;
        if (h < 8 + HB) return preamble(h - 4 - HB, xy(f, v, 1'b0));
        a = h - ACT;
        if (v) return (a % 2 == 0) ? 8'h80 : 8'h10;
        if (!ramp) begin
            bar = a / (AW / 8);
            if (a % 4 == 0) return 8'(bar_cb[bar]);
            if (a % 4 == 2) return 8'(bar_cr[bar]);
            return 8'(bar_y[bar]);
        end
        return (a % 2 == 1) ? 8'(16 + (a / 2) / 4) : 8'h80;
    endfunction

    // Reference model: tracks the raster position at frame/line level.
    bit   m_run;
    int   m_line;
    int   m_h;
    bit   m_pat;
    exp_t m_e;
    initial begin
        m_run = 0; m_line = 0; m_h = 0; m_pat = 0;
        forever begin
            @(posedge ref_clock);
            if (!reset || !enable) begin
                m_run = 0; m_line = 0; m_h = 0;
                exp_valid = 1'b0;
            end else if (!m_run) begin
                m_run = 1; m_line = 0; m_h = 0;
                m_pat = pattern_sel;
                exp_valid = 1'b0;
            end else begin
                m_e.data = ref_word(m_line, m_h, m_pat);
                m_e.fs   = (m_line == 0 && m_h == 0);
                m_e.ls   = (m_h == 0);
                m_e.line = m_line;
                m_e.h    = m_h;
                m_e.ramp = m_pat;
                q.push_back(m_e);
                exp_valid = 1'b1;
                m_h++;
                if (m_h == LW) begin
                    m_h = 0;
                    m_line++;
                    if (m_line == NL) begin
                        m_line = 0;
                        m_pat  = pattern_sel;
                    end
                end
            end
        end
    end

    // Monitor: compares every cycle, pops one expectation per valid word.
    exp_t d_e;
    int   last_fs = -1;
    int   last_ls = -1;
    initial begin
        forever begin
            @(negedge ref_clock);
            check8("valid", 8'(video_if.data_valid), 8'(exp_valid), -1, cyc);
            if (video_if.data_valid !== 1'b1) begin
                check8("idle_data", video_if.bt656_data, 8'h10, -1, cyc);
                check8("idle_strobes", {6'd0, video_if.frame_start, video_if.line_start}, 8'h00, -1, cyc);
                last_fs = -1;
                last_ls = -1;
            end else if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %02h want none (cycle %0d)", video_if.bt656_data, cyc);
            end else begin
                d_e = q.pop_front();
                check8("word", video_if.bt656_data, d_e.data, d_e.line, d_e.h);
                check8("frame_start", 8'(video_if.frame_start), 8'(d_e.fs), d_e.line, d_e.h);
                check8("line_start", 8'(video_if.line_start), 8'(d_e.ls), d_e.line, d_e.h);
                if (d_e.line == 0 && d_e.h == 3)
                    check8("eav_xy_line0", video_if.bt656_data, 8'hB6, d_e.line, d_e.h);
                if (d_e.line == 0 && d_e.h == HB + 7)
                    check8("sav_xy_line0", video_if.bt656_data, 8'hAB, d_e.line, d_e.h);
                if (d_e.line == VB1 && d_e.h == 3)
                    check8("eav_xy_active_f0", video_if.bt656_data, 8'h9D, d_e.line, d_e.h);
                if (d_e.line == VB1 && d_e.h == HB + 7)
                    check8("sav_xy_active_f0", video_if.bt656_data, 8'h80, d_e.line, d_e.h);
                if (d_e.line == F2 && d_e.h == 3)
                    check8("eav_xy_field2", video_if.bt656_data, 8'hF1, d_e.line, d_e.h);
                if (d_e.line == F2 + VB2 && d_e.h == 3)
                    check8("eav_xy_active_f1", video_if.bt656_data, 8'hDA, d_e.line, d_e.h);
                if (d_e.line == VB1 && !d_e.ramp && d_e.h >= ACT && d_e.h < ACT + 4)
                    check8("white_bar", video_if.bt656_data,
                           ((d_e.h - ACT) % 2 == 1) ? 8'hB4 : 8'h80, d_e.line, d_e.h);
                if (d_e.line == VB1 && d_e.ramp && d_e.h == LW - 1)
                    check8("ramp_last_y", video_if.bt656_data, 8'h17, d_e.line, d_e.h);
                if (video_if.line_start === 1'b1) begin
                    if (last_ls >= 0) begin
                        checks++;
                        if (cyc - last_ls != LW) begin
                            failures++;
                            $display("FAIL line_period: got %0d want %0d", cyc - last_ls, LW);
                        end
                    end
                    last_ls = cyc;
                end
                if (video_if.frame_start === 1'b1) begin
                    if (last_fs >= 0) begin
                        checks++;
                        if (cyc - last_fs != FRAME) begin
                            failures++;
                            $display("FAIL frame_period: got %0d want %0d", cyc - last_fs, FRAME);
                        end
                    end
                    last_fs = cyc;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset = 1'b0; enable = 1'b0; pattern_sel = 1'b0;
        repeat (3) @(negedge ref_clock);
        $display("reset released, enable asserted");
        reset = 1'b1; enable = 1'b1;

        // One pattern_sel toggle at a random mid-frame point per frame period.
        for (int k = 0; k < 4; k++) begin
            t = int'($urandom_range(100, FRAME - 100));
            repeat (t) @(negedge ref_clock);
            pattern_sel = ~pattern_sel;
            $display("frame %0d: pattern_sel -> %0d at offset %0d", k, pattern_sel, t);
            repeat (FRAME - t) @(negedge ref_clock);
        end

        t = int'($urandom_range(LW * 5, FRAME - 10));
        repeat (t) @(negedge ref_clock);
        enable = 1'b0;
        $display("enable dropped after %0d cycles", t);
        repeat (5) @(negedge ref_clock);
        pattern_sel = 1'($urandom_range(0, 1));
        enable = 1'b1;
        repeat (FRAME + LW) @(negedge ref_clock);

        t = int'($urandom_range(LW * 5, FRAME - 10));
        repeat (t) @(negedge ref_clock);
        reset = 1'b0;
        $display("reset asserted after %0d cycles", t);
        repeat (5) @(negedge ref_clock);
        pattern_sel = 1'($urandom_range(0, 1));
        reset = 1'b1;
        repeat (FRAME + 200) @(negedge ref_clock);

        enable = 1'b0;
        repeat (3) @(negedge ref_clock);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
